// File: rtl/honzales_scheduler.sv
// Round-robin front end sharing one +1 datapath among several requesters.
// Each granted request is stepped COUNT times and then returned with its ID.
module honzales_inc #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = a + 1'b1;
endmodule

module honzales_scheduler #(
    parameter int WIDTH   = 20,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int CNT_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr, id_q, gnt_idx, ptr_nxt, rid_q;
    logic              gnt_found, accept;
    logic [WIDTH-1:0]  acc, inc, res_q, g_data;
    logic [CNT_W-1:0]  cnt, g_cnt;

    honzales_inc #(.WIDTH(WIDTH)) u_inc (
        .a (acc),
        .y (inc)
    );

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(j);
            end
        end
    end

    assign g_data  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
    assign g_cnt   = req_count[int'(gnt_idx)*CNT_W +: CNT_W];
    assign accept  = (state_q == IDLE) && gnt_found;
    assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = reset;
                    state_d = (g_cnt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers load only on entry to DONE so they hold across later runs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            acc    <= '0;
            cnt    <= '0;
            id_q   <= '0;
            res_q  <= '0;
            rid_q  <= '0;
        end else if (accept) begin
            acc    <= g_data;
            cnt    <= g_cnt;
            id_q   <= gnt_idx;
            rr_ptr <= ptr_nxt;
            if (g_cnt == '0) begin
                res_q <= g_data;
                rid_q <= gnt_idx;
            end
        end else if (state_q == RUN) begin
            acc <= inc;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                res_q <= inc;
                rid_q <= id_q;
            end
        end
    end

    assign resp_data = res_q;
    assign resp_id   = rid_q;
endmodule
